// File: rtl/io_pkg.sv
// Shared constants and helpers for the multi-channel IO source.
// Port summary: none (package only).
// Holds the tag-mode encodings and the channel-index width helper.
package io_pkg;

  // tag_mode encodings
  localparam logic TAG_RAW  = 1'b0;  // out word is the raw sequence value
  localparam logic TAG_CHAN = 1'b1;  // channel id replaces the top CH_W bits

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/io_chan_fifo.sv
// Per-channel synchronous FIFO with first-word-fall-through read data.
// Latency: a pushed word is visible on rdata the cycle after the push (no bypass).
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
// Ports: clk, reset (async active-low), push/wdata, pop/rdata, full, empty.
module io_chan_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  // Extra MSB on each pointer tells full apart from empty when addresses match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the slot the push lands in, so a full FIFO still accepts.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_multi_source.sv
// Multi-channel sequence generator merged round-robin onto one registered stream.
// Latency: tick in cycle N reaches out_valid in cycle N+2 on an idle system.
// Backpressure: per-channel FIFOs absorb stalls; a push into a full FIFO drops the word and sets overflow.
// Ports: clk, reset (async active-low), ch_enable, tag_mode, ovf_clear, out_ready,
//        out_valid/out_data/out_channel (registered output), overflow (sticky per channel).
module io_multi_source
  import io_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int NUM_CH     = 4,
  parameter  int PERIOD     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              tag_mode,
  input  logic              ovf_clear,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic [NUM_CH-1:0] overflow
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [DATA_W-1:0] seq   [NUM_CH];
  logic [DATA_W-1:0] wdata [NUM_CH];
  logic [DATA_W-1:0] rdata [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] drop;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic [DATA_W-1:0] grant_data;
  logic              load;

  assign tick = (cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(i);

    assign push[i]  = tick && ch_enable[i];
    assign pop[i]   = load && (grant == CH_ID);
    // Only a push that finds the FIFO full with no simultaneous pop is lost.
    assign drop[i]  = push[i] && full[i] && !pop[i];
    assign wdata[i] = (tag_mode == TAG_CHAN) ? {CH_ID, seq[i][DATA_W-CH_W-1:0]} : seq[i];

    // Sequence advances on every enabled tick, dropped or not, so gaps mark losses.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)       seq[i] <= '0;
      else if (push[i]) seq[i] <= seq[i] + 1'b1;
    end

    io_chan_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (wdata[i]),
      .rdata (rdata[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Round-robin search: channels at or above rr_ptr first, then wrap to the low ones.
  always_comb begin
    found      = 1'b0;
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && (i >= int'(rr_ptr)) && !empty[i]) begin
        found = 1'b1;
        grant = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && (i < int'(rr_ptr)) && !empty[i]) begin
        found = 1'b1;
        grant = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) grant_data = rdata[i];
    end
  end

  assign load = (!out_valid || out_ready) && found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= grant_data;
      out_channel <= grant;
      rr_ptr      <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // A new drop outranks a clear in the same cycle so no loss goes unreported.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= '0;
    else        overflow <= (overflow & ~{NUM_CH{ovf_clear}}) | drop;
  end

endmodule

// File: tb/tb_io_multi_source.sv
module tb_io_multi_source;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_enable;
  logic        tag_mode;
  logic        ovf_clear;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_channel;
  logic [3:0]  overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] q_data [$];
  logic [1:0]  q_ch   [$];
  int          q_cyc  [$];

  always #5 clk = ~clk;

  io_multi_source #(
    .DATA_W     (32),
    .NUM_CH     (4),
    .PERIOD     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_enable   (ch_enable),
    .tag_mode    (tag_mode),
    .ovf_clear   (ovf_clear),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_channel (out_channel),
    .overflow    (overflow)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Record the word that will be accepted on the coming edge.
  task automatic capture();
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_ch.push_back(out_channel);
      q_cyc.push_back(cyc);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      capture();
    end
  endtask

  // Reset with the given inputs; cycle 1 is the first edge after release.
  task automatic start(input logic [3:0] en, input logic tm, input logic rdy);
    reset     = 1'b0;
    ch_enable = en;
    tag_mode  = tm;
    out_ready = rdy;
    ovf_clear = 1'b0;
    step();
    step();
    reset = 1'b1;
    cyc   = 0;
    q_data.delete();
    q_ch.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    ch_enable = 4'b1111;
    tag_mode  = 1'b0;
    ovf_clear = 1'b0;
    out_ready = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_channel !== 2'd0 || overflow !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h ch=%0d ovf=%b, expected 0/0/0/0",
               out_valid, out_data, out_channel, overflow);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || overflow !== 4'h0) begin
      errors++;
      $display("FAIL reset_held: valid=%b ovf=%b, expected 0/0", out_valid, overflow);
    end
  endtask

  task automatic test_single_channel();
    logic [31:0] exp_d [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
    int          exp_c [4] = '{9, 17, 25, 33};
    start(4'b0001, 1'b0, 1'b1);
    run(8);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: valid=%b at cycle 8, expected 0", out_valid);
    end
    run(26);
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("FAIL single_count: got %0d words, expected 4", q_data.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= q_data.size()) begin
        errors++;
        $display("FAIL single_word%0d: missing, expected %h", k, exp_d[k]);
      end else if (q_data[k] !== exp_d[k] || q_ch[k] !== 2'd0 || q_cyc[k] != exp_c[k]) begin
        errors++;
        $display("FAIL single_word%0d: data=%h ch=%0d cyc=%0d, expected %h/0/%0d",
                 k, q_data[k], q_ch[k], q_cyc[k], exp_d[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_tagged_round_robin();
    logic [31:0] tick6 [4] = '{32'h00000005, 32'h40000005, 32'h80000005, 32'hC0000005};
    logic [31:0] exp_d;
    logic [1:0]  c;
    int          s;
    start(4'b1111, 1'b1, 1'b1);
    run(52);
    checks++;
    if (q_data.size() != 24) begin
      errors++;
      $display("FAIL tagged_count: got %0d words, expected 24", q_data.size());
    end
    for (int k = 0; k < 24 && k < q_data.size(); k++) begin
      c     = 2'(k % 4);
      s     = k / 4;
      exp_d = {c, 30'(s)};
      checks++;
      if (q_data[k] !== exp_d || q_ch[k] !== c || q_cyc[k] != 8 * (s + 1) + 1 + int'(c)) begin
        errors++;
        $display("FAIL tagged_word%0d: data=%h ch=%0d cyc=%0d, expected %h/%0d/%0d",
                 k, q_data[k], q_ch[k], q_cyc[k], exp_d, c, 8 * (s + 1) + 1 + int'(c));
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (20 + k >= q_data.size() || q_data[20 + k] !== tick6[k]) begin
        errors++;
        $display("FAIL tagged_tick6_%0d: got %h, expected %h",
                 k, (20 + k < q_data.size()) ? q_data[20 + k] : 32'hx, tick6[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd6};
    int          exp_c [6] = '{48, 49, 50, 51, 52, 57};
    int          hold_bad = 0;
    start(4'b0001, 1'b0, 1'b0);
    for (int k = 0; k < 47; k++) begin
      step();
      if (cyc >= 9 && (out_valid !== 1'b1 || out_data !== 32'd0 || out_channel !== 2'd0)) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, expected 0", hold_bad);
    end
    checks++;
    if (overflow !== 4'b0000) begin
      errors++;
      $display("FAIL bp_no_ovf_yet: ovf=%b, expected 0000", overflow);
    end
    step();
    checks++;
    if (overflow !== 4'b0001) begin
      errors++;
      $display("FAIL bp_ovf_set: ovf=%b, expected 0001", overflow);
    end
    out_ready = 1'b1;
    capture();
    run(9);
    checks++;
    if (q_data.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d words, expected 6", q_data.size());
    end
    for (int k = 0; k < 6 && k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== exp_d[k] || q_ch[k] !== 2'd0 || q_cyc[k] != exp_c[k]) begin
        errors++;
        $display("FAIL bp_word%0d: data=%h cyc=%0d, expected %h/%0d",
                 k, q_data[k], q_cyc[k], exp_d[k], exp_c[k]);
      end
    end
    checks++;
    if (overflow !== 4'b0001) begin
      errors++;
      $display("FAIL bp_ovf_sticky: ovf=%b, expected 0001", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_d [7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    int          exp_c [7] = '{47, 48, 49, 50, 51, 52, 57};
    start(4'b0001, 1'b0, 1'b0);
    run(47);
    out_ready = 1'b1;
    capture();
    run(10);
    checks++;
    if (q_data.size() != 7) begin
      errors++;
      $display("FAIL fullpop_count: got %0d words, expected 7", q_data.size());
    end
    for (int k = 0; k < 7 && k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== exp_d[k] || q_cyc[k] != exp_c[k]) begin
        errors++;
        $display("FAIL fullpop_word%0d: data=%h cyc=%0d, expected %h/%0d",
                 k, q_data[k], q_cyc[k], exp_d[k], exp_c[k]);
      end
    end
    checks++;
    if (overflow !== 4'b0000) begin
      errors++;
      $display("FAIL fullpop_no_ovf: ovf=%b, expected 0000", overflow);
    end
  endtask

  task automatic test_ovf_clear();
    start(4'b0001, 1'b0, 1'b0);
    run(55);
    checks++;
    if (overflow !== 4'b0001) begin
      errors++;
      $display("FAIL ovfclr_pre: ovf=%b, expected 0001", overflow);
    end
    ovf_clear = 1'b1;
    step();
    checks++;
    if (overflow !== 4'b0001) begin
      errors++;
      $display("FAIL ovfclr_set_wins: ovf=%b, expected 0001", overflow);
    end
    step();
    ovf_clear = 1'b0;
    checks++;
    if (overflow !== 4'b0000) begin
      errors++;
      $display("FAIL ovfclr_cleared: ovf=%b, expected 0000", overflow);
    end
  endtask

  task automatic test_disable();
    logic [31:0] exp_d [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
    int          exp_c [4] = '{24, 25, 26, 57};
    start(4'b0010, 1'b0, 1'b0);
    run(24);
    ch_enable = 4'b0000;
    out_ready = 1'b1;
    capture();
    run(26);
    ch_enable = 4'b0010;
    run(7);
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("FAIL disable_count: got %0d words, expected 4", q_data.size());
    end
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== exp_d[k] || q_ch[k] !== 2'd1 || q_cyc[k] != exp_c[k]) begin
        errors++;
        $display("FAIL disable_word%0d: data=%h ch=%0d cyc=%0d, expected %h/1/%0d",
                 k, q_data[k], q_ch[k], q_cyc[k], exp_d[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_d;
    logic [1:0]  c;
    start(4'b1111, 1'b0, 1'b0);
    run(20);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: valid=%b, expected 1", out_valid);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_channel !== 2'd0 || overflow !== 4'h0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b data=%h ch=%0d ovf=%b, expected 0/0/0/0",
               out_valid, out_data, out_channel, overflow);
    end
    start(4'b1111, 1'b1, 1'b1);
    run(8);
    checks++;
    if (out_valid !== 1'b0 || q_data.size() != 0) begin
      errors++;
      $display("FAIL midrst_stale: valid=%b words=%0d at cycle 8, expected 0/0", out_valid, q_data.size());
    end
    run(5);
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("FAIL midrst_count: got %0d words, expected 4", q_data.size());
    end
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      c     = 2'(k);
      exp_d = {c, 30'd0};
      checks++;
      if (q_data[k] !== exp_d || q_ch[k] !== c || q_cyc[k] != 9 + k) begin
        errors++;
        $display("FAIL midrst_word%0d: data=%h ch=%0d cyc=%0d, expected %h/%0d/%0d",
                 k, q_data[k], q_ch[k], q_cyc[k], exp_d, c, 9 + k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_tagged_round_robin();
    test_backpressure();
    test_full_push_pop();
    test_ovf_clear();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
